// File: rtl/dmem_pkg.sv
// Shared types and constants for the off-chip data-memory line responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int LINE_OFS = 5;
  localparam int CNT_W    = 8;

endpackage

// File: rtl/dmem_line_ram.sv
// Line-wide storage array: one synchronous write port and one synchronous read port, no reset.
module dmem_line_ram #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[idx_i] <= wdata_i;
    if (re_i) r_rdata <= r_mem[idx_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_line_responder.sv
// Responder end of the dcache line refill / write-back port: fixed-latency line access with one-cycle ack.
//
// state   | meaning
// ST_IDLE | waiting for enable_i; a request seen here is latched and accepted
// ST_WAIT | latency countdown; array access happens on the edge that takes the counter to zero
// ST_ACK  | ack_o high for this one cycle, data_o carries read data
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic             DIRECT   = (LATENCY == 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_wait_done;
  logic              w_sel_in;
  logic              w_commit;
  logic              w_is_write;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [IDX_W-1:0]  w_idx_in;
  logic [IDX_W-1:0]  w_ram_idx;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_unused;

  assign w_idx_in    = addr_i[LINE_OFS +: IDX_W];
  assign w_unused    = ^{addr_i[LINE_OFS-1:0], addr_i[ADDR_W-1:LINE_OFS+IDX_W]};

  assign w_accept    = (r_state == ST_IDLE) && enable_i;
  assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

  // Single-cycle latency commits straight from the inputs on the accepting edge.
  assign w_sel_in    = DIRECT && w_accept;
  assign w_commit    = w_wait_done || w_sel_in;
  assign w_is_write  = w_sel_in ? write_i : r_write;
  assign w_ram_idx   = w_sel_in ? w_idx_in : r_idx;
  assign w_ram_wdata = w_sel_in ? data_i : r_wdata;

  // Reset gating keeps a held request from touching the array while rst_i is low.
  assign w_ram_we    = w_commit && rst_i && w_is_write;
  assign w_ram_re    = w_commit && rst_i && !w_is_write;

  dmem_line_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_ram_we),
    .re_i    (w_ram_re),
    .idx_i   (w_ram_idx),
    .wdata_i (w_ram_wdata),
    .rdata_o (w_ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_write <= write_i;
            r_idx   <= w_idx_in;
            r_wdata <= data_i;
            if (DIRECT) begin
              r_state <= ST_ACK;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_wait_done) r_state <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The read port holds its last value, so data_o is masked outside read acks.
  assign ack_o  = (r_state == ST_ACK);
  assign data_o = (ack_o && !r_write) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Scoreboard bench for dmem_line_responder: LATENCY=10 instance plus a LATENCY=1 instance.
module tb_dmem_line_responder;

  localparam int L0 = 10;

  typedef struct {
    bit           is_wr;
    logic [255:0] data;
    int           cyc;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en,  wr,  ack;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;
  logic         en1, wr1, ack1;
  logic [31:0]  addr1;
  logic [255:0] wdata1, rdata1;

  dmem_line_responder #(.LATENCY(L0)) dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en), .write_i(wr), .addr_i(addr),
    .data_i(wdata), .ack_o(ack), .data_o(rdata)
  );

  dmem_line_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
    .data_i(wdata1), .ack_o(ack1), .data_o(rdata1)
  );

  exp_t         q0[$];
  exp_t         q1[$];
  logic [255:0] ref_mem [int];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit w, input logic [255:0] d, input int cy, input string nm);
    exp_t e;
    e.is_wr = w;
    e.data  = d;
    e.cyc   = cy;
    e.name  = nm;
    return e;
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % 512);
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (ack === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_ack", 1, 0);
      end else begin
        e = q0.pop_front();
        check({e.name, "_ack_cycle"}, cyc, e.cyc);
        check({e.name, "_data"}, rdata, e.data);
      end
    end else begin
      check("dut0_ack_low", ack, 1'b0);
      check("dut0_idle_data", rdata, '0);
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_ack", 1, 0);
      end else begin
        e = q1.pop_front();
        check({e.name, "_ack_cycle"}, cyc, e.cyc);
        check({e.name, "_data"}, rdata1, e.data);
      end
    end else begin
      check("dut1_idle_data", rdata1, '0);
    end
  end

  // One request on the LATENCY=10 instance. drop_at/rst_at are cycles after issue (-1 = never).
  task automatic req(input string nm, input bit w, input logic [31:0] a, input logic [255:0] d,
                     input int drop_at, input int rst_at, input bit rel_rst);
    int c, idx;
    bit got, aborted;
    @(negedge clk);
    idx  = line_of(a);
    en   = 1'b1;
    wr   = w;
    addr = a;
    wdata = d;
    if (rel_rst) rst_n = 1'b1;
    c = cyc;
    q0.push_back(mk(w, w ? 256'd0 : ref_mem[idx], c + L0, nm));
    got = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 40 && !got && !aborted; k++) begin
      @(negedge clk);
      if (cyc - c == drop_at) en = 1'b0;
      if (cyc - c == rst_at) begin
        rst_n = 1'b0;
        en = 1'b0;
        void'(q0.pop_back());
        aborted = 1'b1;
      end else if (ack === 1'b1) begin
        got = 1'b1;
      end
    end
    en = 1'b0;
    if (aborted) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end else if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no ack within 40 cycles, ack required", nm);
    end else if (w) begin
      ref_mem[idx] = d;
    end
  endtask

  initial begin : stim
    logic [255:0] d, d6;
    logic [31:0]  a;
    int           c, n, line, drop;
    bit           w;

    rst_n = 1'b0;
    en = 1'b1; wr = 1'b1; addr = 32'h20; wdata = rnd_line();
    en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);

    // Request already held while reset is released.
    req("t1_rst_hold", 1'b1, 32'h20, wdata, -1, -1, 1'b1);

    req("t2_wr40", 1'b1, 32'h40, {8{32'hA5A5_0001}}, -1, -1, 1'b0);
    req("t2_rd40", 1'b0, 32'h40, '0, -1, -1, 1'b0);

    req("t3_rd5f", 1'b0, 32'h5F, '0, -1, -1, 1'b0);
    req("t3_rd4040", 1'b0, 32'h4040, '0, -1, -1, 1'b0);

    req("t4_wr_drop", 1'b1, 32'h60, rnd_line(), 3, -1, 1'b0);
    req("t4_rd60", 1'b0, 32'h60, '0, -1, -1, 1'b0);

    req("t5_wr80_a", 1'b1, 32'h80, rnd_line(), -1, -1, 1'b0);
    req("t5_wr80_rst", 1'b1, 32'h80, rnd_line(), -1, 5, 1'b0);
    req("t5_rd80", 1'b0, 32'h80, '0, -1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      line = ($urandom_range(0, 7) * 37) % 512;
      a    = ($urandom & 32'hFFFF_C01F) | (32'(line) << 5);
      w    = ($urandom_range(0, 1) == 1) || !ref_mem.exists(line);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 8) : -1;
      d    = rnd_line();
      req(w ? "rnd_wr" : "rnd_rd", w, a, d, drop, -1, 1'b0);
    end

    // LATENCY=1 instance: fill a line, then hold a read so it repeats after the idle cycle.
    d6 = rnd_line();
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h100; wdata1 = d6;
    c = cyc;
    q1.push_back(mk(1'b1, '0, c + 1, "t6_wr"));
    n = 0;
    for (int k = 0; k < 10 && n < 1; k++) begin
      @(negedge clk);
      if (ack1 === 1'b1) n++;
    end
    en1 = 1'b0;
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h100;
    c = cyc;
    q1.push_back(mk(1'b0, d6, c + 1, "t6_rd_a"));
    q1.push_back(mk(1'b0, d6, c + 3, "t6_rd_b"));
    n = 0;
    for (int k = 0; k < 10 && n < 2; k++) begin
      @(negedge clk);
      if (ack1 === 1'b1) n++;
    end
    en1 = 1'b0;

    repeat (4) @(negedge clk);
    check("dut0_queue_drained", 256'(q0.size()), 0);
    check("dut1_queue_drained", 256'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
